// File: rtl/nios_system_pio_in.sv
// Avalon-MM parallel input port with per-bit edge capture and a maskable interrupt.
//
// The input pins are synchronised into the clock domain through two flops. A third
// flop holds the previous synchronised value so that edges can be detected. Each
// detected edge latches into a sticky capture register. Any capture bit whose mask
// bit is set drives the interrupt request.
//
// Register map (address):
//   0 data          read-only, synchronised pin state
//   1 reserved      reads 0, writes ignored
//   2 irq_mask      read/write
//   3 edge_capture  read, write-1-to-clear
//
// Parameters:
//   WIDTH      pin / register width (1..32)
//   EDGE_TYPE  0 rising, 1 falling, 2 any edge
//
// Ports:
//   clk         clock for all state
//   reset       asynchronous, active-high reset
//   address     register select
//   chipselect  slave access strobe
//   write_n     active-low write enable
//   writedata   write data; bits at WIDTH and above are ignored
//   in_port     asynchronous external input pins
//   readdata    registered read data, zero-extended, one cycle of latency
//   irq         level interrupt, active-high
module nios_system_pio_in #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clear_bits;
  logic             wr_strobe;

  // Upper write-data bits are architecturally ignored.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  assign wr_strobe = chipselect & ~write_n;

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = sync2_q & ~prev_q;
      1:       edge_det = ~sync2_q & prev_q;
      default: edge_det = sync2_q ^ prev_q;
    endcase
  end

  always_comb begin
    clear_bits = '0;
    if (wr_strobe && address == 2'd3) begin
      clear_bits = writedata[WIDTH-1:0];
    end
  end

  // Edge detection is ORed in after the clear, so a coincident edge wins.
  assign edge_capture_d = (edge_capture_q & ~clear_bits) | edge_det;

  always_comb begin
    irq_mask_d = irq_mask_q;
    if (wr_strobe && address == 2'd2) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
  end

  // Read mux samples current register values; readdata is refreshed every cycle.
  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = sync2_q;
      2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edge_capture_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      prev_q         <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      readdata_q     <= '0;
    end else begin
      sync1_q        <= in_port;
      sync2_q        <= sync1_q;
      prev_q         <= sync2_q;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: doc/nios_system_pio_in.md
NIOS_SYSTEM_PIO_IN -- requirements
Module: nios_system_pio_in

Interface
REQ-001 Parameter WIDTH, default 8: width of in_port and of every internal register (1..32).
REQ-002 Parameter EDGE_TYPE, default 0: edge that sets a capture bit (0 rising, 1 falling, 2 any).
REQ-003 Port clk, input, 1: single clock for all state.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port address, input, 2: register select for the Avalon-MM slave.
REQ-006 Port chipselect, input, 1: slave access strobe.
REQ-007 Port write_n, input, 1: active-low write; chipselect with write_n=1 is a read.
REQ-008 Port writedata, input, 32: write data; bits above WIDTH are ignored.
REQ-009 Port in_port, input, WIDTH: asynchronous external input pins.
REQ-010 Port readdata, output, 32: registered read data, zero-extended above WIDTH.
REQ-011 Port irq, output, 1: level interrupt request, active-high.

Function
REQ-012 in_port SHALL pass through a 2-flop synchronizer (sync1, then sync2); a third register (prev) SHALL hold sync2 delayed one cycle for edge detection.
REQ-013 Edge detect per bit: rising = sync2 & ~prev; falling = ~sync2 & prev; any = sync2 ^ prev; selection per EDGE_TYPE.
REQ-014 Register map: addr 0 = data (sync2, read-only); addr 1 = reserved (reads 0, writes ignored); addr 2 = irq_mask (R/W); addr 3 = edge_capture (read, write-1-to-clear).
REQ-015 Write strobe SHALL be chipselect & ~write_n; it takes effect on the same clk edge.
REQ-016 irq_mask SHALL load writedata[WIDTH-1:0] on a write to addr 2.
REQ-017 edge_capture bit i SHALL set on a detected edge of bit i and stay set until cleared.
REQ-018 A write to addr 3 SHALL clear each edge_capture bit whose writedata bit is 1; bits written 0 are unchanged.
REQ-019 If a bit's edge is detected in the same cycle it is cleared, set SHALL win (bit ends at 1).
REQ-020 readdata SHALL update every clock to the zero-extended value of the register selected by address; it is valid one cycle after the address is presented (read latency 1).
REQ-021 Read side effects: none; reads SHALL NOT clear edge_capture.
REQ-022 irq SHALL be the combinational OR of (edge_capture & irq_mask), derived only from registers.
REQ-023 Latency: in_port change to data readable = 2 clks for sync2, plus 1 for readdata; in_port edge to edge_capture set = 3 clks; to irq high = 3 clks (mask already set).
REQ-024 Writes to addr 0 SHALL be ignored.

Reset
REQ-025 While reset=1, sync1, sync2, prev, irq_mask, edge_capture and readdata SHALL be 0; irq SHALL be 0.
REQ-026 Reset assertion SHALL take effect immediately without a clock; deassertion SHALL be synchronous-safe (registers released on a clk edge).
REQ-027 in_port held high through reset deassertion SHALL produce a rising-edge capture when prev catches up (once, 2-3 clks after release) for EDGE_TYPE 0 or 2; this is defined behaviour.

Verification
REQ-028 Reset; in_port=8'hA5 steady -> after 3 clks, read addr 0 returns 32'h000000A5; edge_capture=8'hA5 (EDGE_TYPE 0, post-reset rise per REQ-027).
REQ-029 EDGE_TYPE 0: write 8'hFF to addr 3, mask=8'h01; drive in_port bit0 0->1 -> edge_capture=8'h01 after 3 clks, irq=1; write 32'h1 to addr 3 -> irq=0 next cycle.
REQ-030 Same cycle: bit3 edge detected while writing 32'h8 to addr 3 -> edge_capture bit3 remains 1, irq stays asserted if mask bit3=1.
REQ-031 mask=8'h00, bit5 toggles -> edge_capture bit5=1, irq=0; then write mask=8'h20 -> irq=1 next cycle.
REQ-032 EDGE_TYPE 1: bit2 1->0 sets capture, 0->1 does not; EDGE_TYPE 2: both transitions set it.
REQ-033 Assert reset mid-operation (capture=8'h3C, mask=8'hFF, irq=1) -> irq, mask, capture, readdata all 0 without a clk edge.
